// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle processor, driving ALU, operand muxes, memory port and writeback
module multicycle_control #(
  parameter int ALU_OP_NUM_BITS = 2,
  parameter int OPCODE_BITS = 4,
  parameter int RETIRE_CNT_BITS = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [OPCODE_BITS-1:0]     opcode,
  input  logic                       zero,
  input  logic                       mem_ready,
  output logic [ALU_OP_NUM_BITS-1:0] ALU_Op,
  output logic                       alu_srcA_sel,
  output logic [1:0]                 alu_srcB_sel,
  output logic                       iord,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic                       ir_write,
  output logic                       mdr_write,
  output logic                       ab_write,
  output logic                       aluout_write,
  output logic                       pc_write,
  output logic                       pc_src,
  output logic                       reg_write,
  output logic                       mem_to_reg,
  output logic                       reg_dst,
  output logic [3:0]                 state,
  output logic                       retire,
  output logic [RETIRE_CNT_BITS-1:0] retire_count,
  output logic                       halted,
  output logic                       illegal
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
    S_ADDR = 4'd4, S_MEM_RD = 4'd5, S_MEM_WR = 4'd6, S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_HALT = 4'd11
  } state_t;
  localparam logic [OPCODE_BITS-1:0] OP_ADD  = OPCODE_BITS'(0);
  localparam logic [OPCODE_BITS-1:0] OP_SUB  = OPCODE_BITS'(1);
  localparam logic [OPCODE_BITS-1:0] OP_ADDI = OPCODE_BITS'(2);
  localparam logic [OPCODE_BITS-1:0] OP_LD   = OPCODE_BITS'(3);
  localparam logic [OPCODE_BITS-1:0] OP_ST   = OPCODE_BITS'(4);
  localparam logic [OPCODE_BITS-1:0] OP_BLE  = OPCODE_BITS'(5);
  localparam logic [OPCODE_BITS-1:0] OP_JMP  = OPCODE_BITS'(6);
  localparam logic [OPCODE_BITS-1:0] OP_NOP  = OPCODE_BITS'(7);
  localparam logic [OPCODE_BITS-1:0] OP_HALT = OPCODE_BITS'(15);
  state_t cur, nxt;
  logic retire_n, illegal_set;
  assign state = cur;
  // State register, registered retire pulse, counter and sticky status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_FETCH;
      retire <= 1'b0;
      retire_count <= '0;
      halted <= 1'b0;
      illegal <= 1'b0;
    end else begin
      cur <= nxt;
      retire <= retire_n;
      retire_count <= retire_count + RETIRE_CNT_BITS'(retire);
      halted <= halted | (nxt == S_HALT);
      illegal <= illegal | illegal_set;
    end
  end
  // Next-state and Moore outputs; only the load enables look at mem_ready or zero
  always_comb begin
    nxt = S_FETCH;
    retire_n = 1'b0;
    illegal_set = 1'b0;
    ALU_Op = '0;
    alu_srcA_sel = 1'b0;
    alu_srcB_sel = 2'd0;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mdr_write = 1'b0;
    ab_write = 1'b0;
    aluout_write = 1'b0;
    pc_write = 1'b0;
    pc_src = 1'b0;
    reg_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read = 1'b1;
        alu_srcB_sel = 2'd1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        nxt = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ab_write = 1'b1;
        case (opcode)
          OP_ADD, OP_SUB: nxt = S_EXEC_R;
          OP_ADDI:        nxt = S_EXEC_I;
          OP_LD, OP_ST:   nxt = S_ADDR;
          OP_BLE:         nxt = S_BRANCH;
          OP_JMP:         nxt = S_JUMP;
          OP_NOP: begin
            nxt = S_FETCH;
            retire_n = 1'b1;
          end
          OP_HALT: begin
            nxt = S_HALT;
            retire_n = 1'b1;
          end
          default: begin
            nxt = S_HALT;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_srcA_sel = 1'b1;
        ALU_Op = ALU_OP_NUM_BITS'(opcode[0]);
        aluout_write = 1'b1;
        nxt = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_srcA_sel = 1'b1;
        alu_srcB_sel = 2'd2;
        aluout_write = 1'b1;
        nxt = S_WB_ALU;
      end
      S_ADDR: begin
        alu_srcA_sel = 1'b1;
        alu_srcB_sel = 2'd2;
        aluout_write = 1'b1;
        nxt = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord = 1'b1;
        mem_read = 1'b1;
        mdr_write = mem_ready;
        nxt = mem_ready ? S_WB_MEM : S_MEM_RD;
      end
      S_MEM_WR: begin
        iord = 1'b1;
        mem_write = 1'b1;
        retire_n = mem_ready;
        nxt = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst = (opcode == OP_ADD) || (opcode == OP_SUB);
        retire_n = 1'b1;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        retire_n = 1'b1;
      end
      S_BRANCH: begin
        alu_srcA_sel = 1'b1;
        ALU_Op = ALU_OP_NUM_BITS'(1);
        pc_write = zero;
        pc_src = 1'b1;
        retire_n = 1'b1;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src = 1'b1;
        retire_n = 1'b1;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multicycle control FSM
module tb_multicycle_control;
  logic clk = 1'b0, reset, zero, mem_ready;
  logic [3:0] opcode;
  logic [1:0] ALU_Op, alu_srcB_sel;
  logic alu_srcA_sel, iord, mem_read, mem_write, ir_write, mdr_write, ab_write, aluout_write;
  logic pc_write, pc_src, reg_write, mem_to_reg, reg_dst, retire, halted, illegal;
  logic [3:0] state;
  logic [31:0] retire_count, exp_cnt;
  logic [3:0] b_count;
  logic [23:0] bo;
  int vecs = 0, errs = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALU_Op(ALU_Op), .alu_srcA_sel(alu_srcA_sel), .alu_srcB_sel(alu_srcB_sel), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .mdr_write(mdr_write),
    .ab_write(ab_write), .aluout_write(aluout_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .state(state),
    .retire(retire), .retire_count(retire_count), .halted(halted), .illegal(illegal)
  );

  multicycle_control #(.RETIRE_CNT_BITS(4)) dut_w (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALU_Op(bo[1:0]), .alu_srcA_sel(bo[2]), .alu_srcB_sel(bo[4:3]), .iord(bo[5]),
    .mem_read(bo[6]), .mem_write(bo[7]), .ir_write(bo[8]), .mdr_write(bo[9]),
    .ab_write(bo[10]), .aluout_write(bo[11]), .pc_write(bo[12]), .pc_src(bo[13]),
    .reg_write(bo[14]), .mem_to_reg(bo[15]), .reg_dst(bo[16]), .state(bo[20:17]),
    .retire(bo[21]), .retire_count(b_count), .halted(bo[22]), .illegal(bo[23])
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_read && mem_write) begin errs++; $display("FAIL strobe_excl: mem_read=1 mem_write=1 state=%0d", state); end
    if (ir_write && mdr_write) begin errs++; $display("FAIL load_excl: ir_write=1 mdr_write=1 state=%0d", state); end
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task test_reset;
    reset = 1'b1; mem_ready = 1'b1; opcode = 4'd0; zero = 1'b0;
    tick(); tick(); #1;
    vecs++; if (state !== 4'd0) begin errs++; $display("FAIL rst_state: got %0d want 0", state); end
    vecs++; if (retire_count !== 32'd0) begin errs++; $display("FAIL rst_count: got %0d want 0", retire_count); end
    vecs++; if ({retire, halted, illegal} !== 3'b000) begin errs++; $display("FAIL rst_flags: got %b want 000", {retire, halted, illegal}); end
    vecs++; if (mem_read !== 1'b1) begin errs++; $display("FAIL rst_mem_read: got %b want 1", mem_read); end
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task test_alu(input logic [3:0] op, input logic [3:0] ex, input logic [1:0] aop, input logic [1:0] sb, input logic dst);
    opcode = op; mem_ready = 1'b1; #1;
    vecs++; if ({state, ir_write, pc_write, mem_read, iord, alu_srcA_sel, alu_srcB_sel, pc_src} !== {4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0})
      begin errs++; $display("FAIL alu%0d_fetch: got st=%0d ir=%b pc=%b rd=%b iord=%b a=%b b=%0d", op, state, ir_write, pc_write, mem_read, iord, alu_srcA_sel, alu_srcB_sel); end
    tick();
    vecs++; if ({state, ab_write} !== {4'd1, 1'b1}) begin errs++; $display("FAIL alu%0d_decode: got st=%0d ab=%b want 1/1", op, state, ab_write); end
    tick();
    vecs++; if ({state, ALU_Op, alu_srcA_sel, alu_srcB_sel, aluout_write} !== {ex, aop, 1'b1, sb, 1'b1})
      begin errs++; $display("FAIL alu%0d_exec: got st=%0d op=%0d a=%b b=%0d aw=%b want st=%0d op=%0d b=%0d", op, state, ALU_Op, alu_srcA_sel, alu_srcB_sel, aluout_write, ex, aop, sb); end
    tick(); mem_ready = 1'b0; #1;
    vecs++; if ({state, reg_write, reg_dst, mem_to_reg} !== {4'd7, 1'b1, dst, 1'b0})
      begin errs++; $display("FAIL alu%0d_wb: got st=%0d rw=%b dst=%b m2r=%b want dst=%b", op, state, reg_write, reg_dst, mem_to_reg, dst); end
    tick();
    vecs++; if ({state, retire, ir_write} !== {4'd0, 1'b1, 1'b0}) begin errs++; $display("FAIL alu%0d_retire: got st=%0d ret=%b ir=%b want 0/1/0", op, state, retire, ir_write); end
    tick(); exp_cnt++;
    vecs++; if ({retire, retire_count} !== {1'b0, exp_cnt}) begin errs++; $display("FAIL alu%0d_count: got ret=%b cnt=%0d want 0/%0d", op, retire, retire_count, exp_cnt); end
  endtask

  task test_ld;
    opcode = 4'd3; mem_ready = 1'b1; #1;
    tick(); tick();
    vecs++; if ({state, alu_srcB_sel, aluout_write} !== {4'd4, 2'd2, 1'b1}) begin errs++; $display("FAIL ld_addr: got st=%0d b=%0d aw=%b want 4/2/1", state, alu_srcB_sel, aluout_write); end
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      vecs++; if ({state, iord, mem_read, mem_write, mdr_write} !== {4'd5, 1'b1, 1'b1, 1'b0, i == 3})
        begin errs++; $display("FAIL ld_memrd%0d: got st=%0d iord=%b rd=%b wr=%b mdr=%b", i, state, iord, mem_read, mem_write, mdr_write); end
      tick();
    end
    mem_ready = 1'b0; #1;
    vecs++; if ({state, reg_write, mem_to_reg, reg_dst} !== {4'd8, 1'b1, 1'b1, 1'b0}) begin errs++; $display("FAIL ld_wbmem: got st=%0d rw=%b m2r=%b dst=%b want 8/1/1/0", state, reg_write, mem_to_reg, reg_dst); end
    tick();
    vecs++; if ({state, retire} !== {4'd0, 1'b1}) begin errs++; $display("FAIL ld_retire: got st=%0d ret=%b want 0/1", state, retire); end
    tick(); exp_cnt++;
    vecs++; if (retire_count !== exp_cnt) begin errs++; $display("FAIL ld_count: got %0d want %0d", retire_count, exp_cnt); end
  endtask

  task test_ble(input logic z);
    opcode = 4'd5; zero = z; mem_ready = 1'b1; #1;
    tick(); mem_ready = 1'b0;
    tick();
    vecs++; if ({state, ALU_Op, alu_srcA_sel, alu_srcB_sel, pc_src, pc_write} !== {4'd9, 2'd1, 1'b1, 2'd0, 1'b1, z})
      begin errs++; $display("FAIL ble_z%b: got st=%0d op=%0d a=%b b=%0d src=%b pcw=%b", z, state, ALU_Op, alu_srcA_sel, alu_srcB_sel, pc_src, pc_write); end
    tick();
    vecs++; if ({state, retire} !== {4'd0, 1'b1}) begin errs++; $display("FAIL ble_z%b_retire: got st=%0d ret=%b want 0/1", z, state, retire); end
    tick(); exp_cnt++;
    vecs++; if (retire_count !== exp_cnt) begin errs++; $display("FAIL ble_z%b_count: got %0d want %0d", z, retire_count, exp_cnt); end
    zero = 1'b0;
  endtask

  task test_nop_jmp;
    opcode = 4'd7; mem_ready = 1'b1; #1;
    tick(); mem_ready = 1'b0;
    tick();
    vecs++; if ({state, retire} !== {4'd0, 1'b1}) begin errs++; $display("FAIL nop_retire: got st=%0d ret=%b want 0/1", state, retire); end
    tick(); exp_cnt++;
    opcode = 4'd6; mem_ready = 1'b1; #1;
    tick(); mem_ready = 1'b0;
    tick();
    vecs++; if ({state, pc_write, pc_src} !== {4'd10, 1'b1, 1'b1}) begin errs++; $display("FAIL jmp_state: got st=%0d pcw=%b src=%b want 10/1/1", state, pc_write, pc_src); end
    tick();
    vecs++; if ({state, retire} !== {4'd0, 1'b1}) begin errs++; $display("FAIL jmp_retire: got st=%0d ret=%b want 0/1", state, retire); end
    tick(); exp_cnt++;
    vecs++; if (retire_count !== exp_cnt) begin errs++; $display("FAIL jmp_count: got %0d want %0d", retire_count, exp_cnt); end
  endtask

  task test_illegal;
    opcode = 4'd9; mem_ready = 1'b1; #1;
    tick(); tick();
    vecs++; if ({state, illegal, halted, retire} !== {4'd11, 1'b1, 1'b1, 1'b0}) begin errs++; $display("FAIL ill_halt: got st=%0d ill=%b hlt=%b ret=%b want 11/1/1/0", state, illegal, halted, retire); end
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0]; #1;
      vecs++; if ({state, mem_read, mem_write, ir_write, pc_write, retire, halted} !== {4'd11, 5'b0, 1'b1})
        begin errs++; $display("FAIL ill_hold%0d: got st=%0d rd=%b wr=%b ir=%b pcw=%b ret=%b hlt=%b", i, state, mem_read, mem_write, ir_write, pc_write, retire, halted); end
      tick();
    end
    vecs++; if (retire_count !== exp_cnt) begin errs++; $display("FAIL ill_count: got %0d want %0d", retire_count, exp_cnt); end
  endtask

  task test_halt;
    opcode = 4'd15; mem_ready = 1'b1; #1;
    tick(); tick();
    vecs++; if ({state, halted, illegal, retire} !== {4'd11, 1'b1, 1'b0, 1'b1}) begin errs++; $display("FAIL halt_op: got st=%0d hlt=%b ill=%b ret=%b want 11/1/0/1", state, halted, illegal, retire); end
    tick(); exp_cnt++;
    vecs++; if ({state, retire_count} !== {4'd11, exp_cnt}) begin errs++; $display("FAIL halt_count: got st=%0d cnt=%0d want 11/%0d", state, retire_count, exp_cnt); end
  endtask

  task test_st_reset;
    opcode = 4'd4; mem_ready = 1'b1; #1;
    tick(); tick(); tick();
    vecs++; if ({state, iord, mem_write, mem_read} !== {4'd6, 1'b1, 1'b1, 1'b0}) begin errs++; $display("FAIL st_memwr: got st=%0d iord=%b wr=%b rd=%b want 6/1/1/0", state, iord, mem_write, mem_read); end
    tick();
    vecs++; if ({state, retire} !== {4'd0, 1'b1}) begin errs++; $display("FAIL st_retire: got st=%0d ret=%b want 0/1", state, retire); end
    tick(); exp_cnt++;
    vecs++; if (retire_count !== exp_cnt) begin errs++; $display("FAIL st_count: got %0d want %0d", retire_count, exp_cnt); end
    tick(); mem_ready = 1'b0;
    tick(); tick();
    vecs++; if ({state, mem_write} !== {4'd6, 1'b1}) begin errs++; $display("FAIL st_wait: got st=%0d wr=%b want 6/1", state, mem_write); end
    reset = 1'b1;
    tick();
    vecs++; if ({state, mem_write, mem_read, retire, halted, illegal} !== {4'd0, 1'b0, 1'b1, 3'b000} || retire_count !== 32'd0)
      begin errs++; $display("FAIL st_reset: got st=%0d wr=%b rd=%b ret=%b hlt=%b ill=%b cnt=%0d", state, mem_write, mem_read, retire, halted, illegal, retire_count); end
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task test_wrap;
    opcode = 4'd7;
    for (int i = 0; i < 16; i++) begin
      mem_ready = 1'b1; tick();
      mem_ready = 1'b0; tick();
    end
    vecs++; if (b_count !== 4'd15) begin errs++; $display("FAIL wrap_allones: got %0d want 15", b_count); end
    tick();
    vecs++; if (b_count !== 4'd0) begin errs++; $display("FAIL wrap_zero: got %0d want 0", b_count); end
    vecs++; if (retire_count !== 32'd16) begin errs++; $display("FAIL wrap_wide: got %0d want 16", retire_count); end
  endtask

  initial begin
    test_reset();
    test_alu(4'd0, 4'd2, 2'd0, 2'd0, 1'b1);
    test_alu(4'd1, 4'd2, 2'd1, 2'd0, 1'b1);
    test_alu(4'd2, 4'd3, 2'd0, 2'd2, 1'b0);
    test_ld();
    test_ble(1'b1);
    test_ble(1'b0);
    test_nop_jmp();
    test_illegal();
    do_reset();
    test_halt();
    do_reset();
    test_st_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
